// File: rtl/cpu_pkg.sv
// cpu_pkg -- encodings shared between the instruction decoder and the
// T-state sequencer.
//   state_t : 6-bit sequencer state codes (the decoder drives one of the
//             *_T2 / T0_FETCH codes as the first post-decode state)
//   ADDR_*  : address-source selects driven on o_addr_sel
package cpu_pkg;

  typedef enum logic [5:0] {
    T0_FETCH  = 6'h00,
    T1_DECODE = 6'h01,
    ZPG_T2    = 6'h02,
    ABS_T2    = 6'h03,
    ABS_T3    = 6'h04,
    ZPGXY_T2  = 6'h05,
    ZPGXY_T3  = 6'h06,
    ABSXY_T2  = 6'h07,
    ABSXY_T3  = 6'h08,
    ABSXY_T4  = 6'h09,
    XIND_T2   = 6'h0A,
    XIND_T3   = 6'h0B,
    XIND_T4   = 6'h0C,
    XIND_T5   = 6'h0D,
    INDY_T2   = 6'h0E,
    INDY_T3   = 6'h0F,
    INDY_T4   = 6'h10,
    INDY_T5   = 6'h11,
    RMW_DUMMY = 6'h12,
    RMW_WB    = 6'h13,
    T2_BRK    = 6'h14,
    T2_JMP    = 6'h15,
    T2_STACK  = 6'h16,
    T2_BRANCH = 6'h17,
    S_EXT     = 6'h18,
    T_JAM     = 6'h19
  } state_t;

  localparam logic [2:0] ADDR_PC     = 3'd0;
  localparam logic [2:0] ADDR_ZP     = 3'd1;
  localparam logic [2:0] ADDR_ZPIDX  = 3'd2;
  localparam logic [2:0] ADDR_ABS    = 3'd3;
  localparam logic [2:0] ADDR_ABSIDX = 3'd4;
  localparam logic [2:0] ADDR_PTR    = 3'd5;
  localparam logic [2:0] ADDR_PTR1   = 3'd6;

endpackage

// File: rtl/tstate_seq.sv
// tstate_seq -- per-instruction T-state sequencer.
// Walks fetch/decode, the addressing-mode cycles and the access cycle
// (read/load/store/rmw), hands control-flow opcodes to an external
// sequencer, and halts in T_JAM on an unknown first state.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_rdy              bus ready; low stalls read cycles only
//   i_initial_state    first post-decode state, sampled in T1_DECODE
//   i_single_byte      opcode has no operand byte (no PC inc in T1)
//   i_read/i_load/i_store/i_rmw  access class, one-hot
//   i_page_cross       effective-address carry (ABSXY_T3 / INDY_T4 only)
//   i_ext_done         external control-flow sequencer finished
//   o_state            current state code
//   o_sync, o_rw, o_addr_sel, o_pc_inc, o_ir_ld, o_ext_start, o_jam
// Build option: define PAGE_SKIP_EN to drop the index fix cycle for
// read/load when no page is crossed. Default build always takes it.
// State register is clocked; outputs are decoded from the state.
module tstate_seq
  import cpu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rdy,
  input  logic [5:0] i_initial_state,
  input  logic       i_single_byte,
  input  logic       i_read,
  input  logic       i_load,
  input  logic       i_store,
  input  logic       i_rmw,
  input  logic       i_page_cross,
  input  logic       i_ext_done,
  output logic [5:0] o_state,
  output logic       o_sync,
  output logic       o_rw,
  output logic [2:0] o_addr_sel,
  output logic       o_pc_inc,
  output logic       o_ir_ld,
  output logic       o_ext_start,
  output logic       o_jam
);

  state_t     r_state;
  logic [2:0] r_rmw_addr;

  state_t     w_next;
  logic       w_rw, w_sync, w_pc_inc, w_ir_ld, w_ext_start, w_jam;
  logic [2:0] w_addr;
  logic       w_access;
  logic       w_stall;
  logic       w_skip_cond;
  logic       w_skip;

  assign w_skip_cond = (i_read | i_load) & ~i_page_cross;
`ifdef PAGE_SKIP_EN
  assign w_skip = w_skip_cond;
`else
  // Uniform timing: the fix cycle is always taken.
  assign w_skip = w_skip_cond & 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_rw        = 1'b1;
    w_addr      = ADDR_PC;
    w_sync      = 1'b0;
    w_pc_inc    = 1'b0;
    w_ir_ld     = 1'b0;
    w_ext_start = 1'b0;
    w_jam       = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      T0_FETCH: begin
        w_sync   = 1'b1;
        w_ir_ld  = 1'b1;
        w_pc_inc = 1'b1;
        w_next   = T1_DECODE;
      end
      T1_DECODE: begin
        w_pc_inc = ~i_single_byte;
        case (i_initial_state)
          T0_FETCH, ZPG_T2, ABS_T2, ZPGXY_T2, ABSXY_T2, XIND_T2, INDY_T2,
          T2_BRK, T2_JMP, T2_STACK, T2_BRANCH:
            w_next = state_t'(i_initial_state);
          default: w_next = T_JAM;
        endcase
      end
      ZPG_T2:   begin w_addr = ADDR_ZP;     w_access = 1'b1; end
      ABS_T2:   begin w_pc_inc = 1'b1;      w_next = ABS_T3; end
      ABS_T3:   begin w_addr = ADDR_ABS;    w_access = 1'b1; end
      ZPGXY_T2: begin w_addr = ADDR_ZP;     w_next = ZPGXY_T3; end
      ZPGXY_T3: begin w_addr = ADDR_ZPIDX;  w_access = 1'b1; end
      ABSXY_T2: begin w_pc_inc = 1'b1;      w_next = ABSXY_T3; end
      ABSXY_T3: begin
        // Read at the unfixed index address; it is the real access only
        // when the fix cycle may be skipped.
        w_addr = ADDR_ABSIDX;
        if (w_skip) w_access = 1'b1;
        else        w_next   = ABSXY_T4;
      end
      ABSXY_T4: begin w_addr = ADDR_ABSIDX; w_access = 1'b1; end
      XIND_T2:  begin w_addr = ADDR_ZP;     w_next = XIND_T3; end
      XIND_T3:  begin w_addr = ADDR_PTR;    w_next = XIND_T4; end
      XIND_T4:  begin w_addr = ADDR_PTR1;   w_next = XIND_T5; end
      XIND_T5:  begin w_addr = ADDR_ABS;    w_access = 1'b1; end
      INDY_T2:  begin w_addr = ADDR_PTR;    w_next = INDY_T3; end
      INDY_T3:  begin w_addr = ADDR_PTR1;   w_next = INDY_T4; end
      INDY_T4: begin
        w_addr = ADDR_ABSIDX;
        if (w_skip) w_access = 1'b1;
        else        w_next   = INDY_T5;
      end
      INDY_T5:  begin w_addr = ADDR_ABSIDX; w_access = 1'b1; end
      RMW_DUMMY: begin w_addr = r_rmw_addr; w_rw = 1'b0; w_next = RMW_WB; end
      RMW_WB:    begin w_addr = r_rmw_addr; w_rw = 1'b0; w_next = T0_FETCH; end
      T2_BRK, T2_JMP, T2_STACK, T2_BRANCH: begin
        w_ext_start = 1'b1;
        w_next      = S_EXT;
      end
      S_EXT:   if (i_ext_done) w_next = T0_FETCH;
      T_JAM:   w_jam = 1'b1;
      default: w_next = T_JAM;
    endcase

    if (w_access) begin
      if (i_store) w_rw = 1'b0;
      w_next = i_rmw ? RMW_DUMMY : T0_FETCH;
    end

    // Not-ready only stalls read cycles; writes always complete.
    w_stall = w_rw & ~i_rdy;
    if (w_stall) begin
      w_next      = r_state;
      w_pc_inc    = 1'b0;
      w_ir_ld     = 1'b0;
      w_ext_start = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= T0_FETCH;
      r_rmw_addr <= ADDR_PC;
    end else begin
      r_state <= w_next;
      // RMW dummy and write-back cycles reuse the access address.
      if (w_access && i_rmw && !w_stall) r_rmw_addr <= w_addr;
    end
  end

  // Reset forces a safe idle bus in the same cycle so an aborted write
  // never reaches memory.
  assign o_state     = r_state;
  assign o_rw        = w_rw | i_rst;
  assign o_addr_sel  = i_rst ? ADDR_PC : w_addr;
  assign o_sync      = w_sync      & ~i_rst;
  assign o_pc_inc    = w_pc_inc    & ~i_rst;
  assign o_ir_ld     = w_ir_ld     & ~i_rst;
  assign o_ext_start = w_ext_start & ~i_rst;
  assign o_jam       = w_jam       & ~i_rst;

endmodule

// File: tb/tb_tstate_seq.sv
module tb_tstate_seq;
  import cpu_pkg::*;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rdy = 1'b1;
  logic [5:0] i_initial_state = 6'h00;
  logic       i_single_byte = 1'b0;
  logic       i_read = 1'b0, i_load = 1'b1, i_store = 1'b0, i_rmw = 1'b0;
  logic       i_page_cross = 1'b0;
  logic       i_ext_done = 1'b0;
  logic [5:0] o_state;
  logic       o_sync, o_rw, o_pc_inc, o_ir_ld, o_ext_start, o_jam;
  logic [2:0] o_addr_sel;

  tstate_seq dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rdy(i_rdy),
    .i_initial_state(i_initial_state), .i_single_byte(i_single_byte),
    .i_read(i_read), .i_load(i_load), .i_store(i_store), .i_rmw(i_rmw),
    .i_page_cross(i_page_cross), .i_ext_done(i_ext_done),
    .o_state(o_state), .o_sync(o_sync), .o_rw(o_rw), .o_addr_sel(o_addr_sel),
    .o_pc_inc(o_pc_inc), .o_ir_ld(o_ir_ld), .o_ext_start(o_ext_start),
    .o_jam(o_jam)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       nm;
    logic [14:0] v;   // {state, rw, addr, sync, pc_inc, ir_ld, ext_start, jam}
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge i_clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [14:0] act;
      e   = sb.pop_front();
      act = {o_state, o_rw, o_addr_sel, o_sync, o_pc_inc, o_ir_ld, o_ext_start, o_jam};
      n_tests++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got st=%h rw=%b addr=%0d sync=%b pc=%b ir=%b ext=%b jam=%b, want st=%h rw=%b addr=%0d sync=%b pc=%b ir=%b ext=%b jam=%b",
                 e.nm, act[14:9], act[8], act[7:5], act[4], act[3], act[2], act[1], act[0],
                 e.v[14:9], e.v[8], e.v[7:5], e.v[4], e.v[3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  task automatic step(input string nm, input state_t st, input logic rw,
                      input logic [2:0] ad, input logic sy, input logic pc,
                      input logic ir, input logic ex, input logic jm);
    exp_t e;
    e.nm = nm;
    e.v  = {st, rw, ad, sy, pc, ir, ex, jm};
    sb.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic t0(input string nm);
    step(nm, T0_FETCH, 1'b1, ADDR_PC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic t1(input string nm, input logic pc);
    step(nm, T1_DECODE, 1'b1, ADDR_PC, 1'b0, pc, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic instr(input state_t init, input logic single,
                       input logic r, input logic l, input logic s, input logic m);
    i_initial_state = init;
    i_single_byte   = single;
    i_read = r; i_load = l; i_store = s; i_rmw = m;
  endtask

  initial begin
    @(posedge i_clk); #1;
    step("reset", T0_FETCH, 1'b1, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;

    // LDA abs
    instr(ABS_T2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    t0("lda_abs_t0"); t1("lda_abs_t1", 1'b1);
    step("lda_abs_t2", ABS_T2, 1'b1, ADDR_PC,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("lda_abs_t3", ABS_T3, 1'b1, ADDR_ABS, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // LDA abs,X, no page cross
    instr(ABSXY_T2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    t0("ldax_nc_t0"); t1("ldax_nc_t1", 1'b1);
    step("ldax_nc_t2", ABSXY_T2, 1'b1, ADDR_PC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    i_page_cross = 1'b0;
    step("ldax_nc_t3", ABSXY_T3, 1'b1, ADDR_ABSIDX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifndef PAGE_SKIP_EN
    step("ldax_nc_t4", ABSXY_T4, 1'b1, ADDR_ABSIDX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // LDA abs,X, page cross
    t0("ldax_pc_t0"); t1("ldax_pc_t1", 1'b1);
    step("ldax_pc_t2", ABSXY_T2, 1'b1, ADDR_PC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    i_page_cross = 1'b1;
    step("ldax_pc_t3", ABSXY_T3, 1'b1, ADDR_ABSIDX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_page_cross = 1'b0;
    step("ldax_pc_t4", ABSXY_T4, 1'b1, ADDR_ABSIDX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // STA abs,X, no page cross: fix cycle always taken
    instr(ABSXY_T2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    t0("stax_t0"); t1("stax_t1", 1'b1);
    step("stax_t2", ABSXY_T2, 1'b1, ADDR_PC,     1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("stax_t3", ABSXY_T3, 1'b1, ADDR_ABSIDX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("stax_t4", ABSXY_T4, 1'b0, ADDR_ABSIDX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // INC zpg
    instr(ZPG_T2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    t0("inc_t0"); t1("inc_t1", 1'b1);
    step("inc_t2",  ZPG_T2,    1'b1, ADDR_ZP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("inc_dum", RMW_DUMMY, 1'b0, ADDR_ZP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("inc_wb",  RMW_WB,    1'b0, ADDR_ZP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // LDA zpg with 3 not-ready cycles in T2
    instr(ZPG_T2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    t0("ldz_t0"); t1("ldz_t1", 1'b1);
    i_rdy = 1'b0;
    for (int k = 0; k < 3; k++)
      step("ldz_stall", ZPG_T2, 1'b1, ADDR_ZP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rdy = 1'b1;
    step("ldz_t2", ZPG_T2, 1'b1, ADDR_ZP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // NOP (implied, single byte): execute overlaps next fetch
    instr(T0_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    t0("nop_t0"); t1("nop_t1", 1'b0);

    // LDA (zp,X)
    instr(XIND_T2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    t0("xind_t0"); t1("xind_t1", 1'b1);
    step("xind_t2", XIND_T2, 1'b1, ADDR_ZP,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("xind_t3", XIND_T3, 1'b1, ADDR_PTR,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("xind_t4", XIND_T4, 1'b1, ADDR_PTR1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("xind_t5", XIND_T5, 1'b1, ADDR_ABS,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // STA (zp),Y
    instr(INDY_T2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    t0("indy_t0"); t1("indy_t1", 1'b1);
    step("indy_t2", INDY_T2, 1'b1, ADDR_PTR,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("indy_t3", INDY_T3, 1'b1, ADDR_PTR1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("indy_t4", INDY_T4, 1'b1, ADDR_ABSIDX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("indy_t5", INDY_T5, 1'b0, ADDR_ABSIDX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // LDA zp,X
    instr(ZPGXY_T2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    t0("zpx_t0"); t1("zpx_t1", 1'b1);
    step("zpx_t2", ZPGXY_T2, 1'b1, ADDR_ZP,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("zpx_t3", ZPGXY_T3, 1'b1, ADDR_ZPIDX, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // JMP: external sequencer takes 3 cycles
    instr(T2_JMP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    t0("jmp_t0"); t1("jmp_t1", 1'b1);
    step("jmp_t2", T2_JMP, 1'b1, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("jmp_ext0", S_EXT, 1'b1, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("jmp_ext1", S_EXT, 1'b1, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_ext_done = 1'b1;
    step("jmp_ext2", S_EXT, 1'b1, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch with ext_done already high: S_EXT still costs one cycle
    instr(T2_BRANCH, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    t0("br_t0"); t1("br_t1", 1'b1);
    step("br_t2",  T2_BRANCH, 1'b1, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("br_ext", S_EXT,     1'b1, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_ext_done = 1'b0;

    // Reset during the RMW dummy write: no write issued, abort to T0
    instr(ZPG_T2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    t0("rrmw_t0"); t1("rrmw_t1", 1'b1);
    step("rrmw_t2", ZPG_T2, 1'b1, ADDR_ZP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b1;
    step("rrmw_rst", RMW_DUMMY, 1'b1, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    instr(T0_FETCH, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    t0("rrmw_t0b"); t1("rrmw_t1b", 1'b0);

    // Unlisted initial state: jam until reset
    instr(state_t'(6'h3F), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    t0("jam_t0"); t1("jam_t1", 1'b1);
    for (int k = 0; k < 4; k++)
      step("jam_hold", T_JAM, 1'b1, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    i_rst = 1'b1;
    step("jam_rst", T_JAM, 1'b1, ADDR_PC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    i_rst = 1'b0;
    t0("jam_after");

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
